// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives ROM reads and keeps a small prefetch FIFO feeding ID.
// Redirects (jCe) and reset flush everything in flight and restart fetching at the new PC.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jCe,
  input  logic [ADDR_W-1:0]        jAddr,
  output logic                     romCe,
  output logic [ADDR_W-1:0]        pc,
  input  logic [DATA_W-1:0]        romData,
  output logic                     instValid,
  output logic [DATA_W-1:0]        inst,
  output logic [ADDR_W-1:0]        instPc,
  input  logic                     idReady,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pendPc;
  logic              r_pend;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [DATA_W-1:0] r_instMem [DEPTH];
  logic [ADDR_W-1:0] r_pcMem   [DEPTH];

  logic [CW:0] w_occ;
  logic        w_romCe;
  logic        w_push;
  logic        w_pop;

  // Credit check counts the in-flight read so a returning word always has a free slot.
  assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_pend};
  assign w_romCe = !rst && !jCe && (w_occ < DEPTH_C);
  assign w_push  = r_pend && !jCe;
  assign w_pop   = !rst && !jCe && idReady && (r_count != '0);

  assign romCe     = w_romCe;
  assign pc        = r_pc;
  assign instValid = !rst && (r_count != '0);
  assign count     = rst ? '0 : r_count;
  assign inst      = r_instMem[r_rp];
  assign instPc    = r_pcMem[r_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_pend   <= 1'b0;
      r_pendPc <= '0;
      r_count  <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else if (jCe) begin
      // Redirect drops the in-flight word and the whole buffer.
      r_pc     <= jAddr;
      r_pend   <= 1'b0;
      r_count  <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else begin
      if (w_romCe) begin
        r_pc     <= r_pc + ADDR_W'(PC_STEP);
        r_pend   <= 1'b1;
        r_pendPc <= r_pc;
      end else begin
        r_pend   <= 1'b0;
      end
      if (w_push) begin
        r_instMem[r_wp] <= romData;
        r_pcMem[r_wp]   <= r_pendPc;
        r_wp            <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
